// File: rtl/gray_port_arbiter.sv
// Two-requester read arbiter in front of the gray-image memory.
// Requests are decided combinationally, issued one cycle later as a registered
// memory read, and the returned data is routed back through a two-stage owner
// tag pipeline so each requester only ever sees the data it asked for.
// A requester may hold a lock for burst fetches (e.g. a 3x3 window); a lock is
// force-released after LOCK_MAX grants so the other requester cannot starve.

module gray_port_arbiter #(
  parameter int unsigned AW       = 14,
  parameter int unsigned DW       = 8,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_gray_ready,
  output logic          o_m_req,
  output logic [AW-1:0] o_m_addr,
  input  logic [DW-1:0] i_m_data,
  input  logic          i_r0_req,
  input  logic [AW-1:0] i_r0_addr,
  input  logic          i_r0_lock,
  output logic          o_r0_gnt,
  output logic          o_r0_rvalid,
  output logic [DW-1:0] o_r0_rdata,
  input  logic          i_r1_req,
  input  logic [AW-1:0] i_r1_addr,
  input  logic          i_r1_lock,
  output logic          o_r1_gnt,
  output logic          o_r1_rvalid,
  output logic [DW-1:0] o_r1_rdata,
  output logic          o_busy
);

  localparam int unsigned   CW         = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    StWaitRdy = 2'd0,
    StArb     = 2'd1,
    StLocked  = 2'd2
  } state_e;

  // Arbitration state
  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_ptr;        // round-robin priority: 0 -> r0 first, 1 -> r1 first
  logic          w_ptr_nxt;
  logic          r_owner;      // lock owner, meaningful only in StLocked
  logic          w_owner_nxt;
  logic [CW-1:0] r_lock_cnt;   // grants issued to the owner in the current lock tenure
  logic [CW-1:0] w_cnt_nxt;

  // Decision of the current cycle
  logic          w_gnt_vld;
  logic          w_gnt_id;
  logic          w_own_req;
  logic          w_own_lock;

  // Issue stage
  logic          r_m_req;
  logic [AW-1:0] r_m_addr;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_tag1_vld;
  logic          r_tag1_own;

  // Return stage
  logic          r_tag2_vld;
  logic          r_tag2_own;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  assign w_own_req  = r_owner ? i_r1_req  : i_r0_req;
  assign w_own_lock = r_owner ? i_r1_lock : i_r0_lock;

  // Next-state, grant decision, pointer and lock bookkeeping
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_lock_cnt;
    w_gnt_vld   = 1'b0;
    w_gnt_id    = 1'b0;
    case (r_state)
      StWaitRdy: begin
        if (i_gray_ready) begin
          w_state_nxt = StArb;
        end
      end
      StArb: begin
        if (!i_gray_ready) begin
          w_state_nxt = StWaitRdy;
        end else if (i_r0_req || i_r1_req) begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = (i_r0_req && i_r1_req) ? r_ptr : i_r1_req;
          w_ptr_nxt = ~w_gnt_id;
          // The entry grant is the first grant of the tenure, so the counter
          // restarts at one; with LOCK_MAX of one a lock could never hold.
          if ((LOCK_MAX > 1) && (w_gnt_id ? i_r1_lock : i_r0_lock)) begin
            w_state_nxt = StLocked;
            w_owner_nxt = w_gnt_id;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      StLocked: begin
        w_gnt_id = r_owner;
        if (!i_gray_ready) begin
          w_state_nxt = StWaitRdy;
          w_cnt_nxt   = '0;
        end else begin
          if (w_own_req) begin
            w_gnt_vld = 1'b1;
            if (r_lock_cnt != LOCK_MAX_C) begin
              w_cnt_nxt = r_lock_cnt + CNT_ONE;
            end
          end
          if (w_cnt_nxt == LOCK_MAX_C) begin
            // Forced release hands priority to the requester that was locked out
            w_state_nxt = StArb;
            w_ptr_nxt   = ~r_owner;
            w_cnt_nxt   = '0;
          end else if (!w_own_lock) begin
            w_state_nxt = StArb;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = StWaitRdy;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state, priority pointer, lock owner and lock counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StWaitRdy;
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_cnt_nxt;
    end
  end

  // Issue stage: registered memory request, grant strobes and first owner tag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_req    <= 1'b0;
      r_m_addr   <= '0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_tag1_vld <= 1'b0;
      r_tag1_own <= 1'b0;
    end else begin
      r_m_req    <= w_gnt_vld;
      r_gnt0     <= w_gnt_vld && !w_gnt_id;
      r_gnt1     <= w_gnt_vld && w_gnt_id;
      r_tag1_vld <= w_gnt_vld;
      r_tag1_own <= w_gnt_id;
      if (w_gnt_vld) begin
        r_m_addr <= w_gnt_id ? i_r1_addr : i_r0_addr;
      end
    end
  end

  // Return stage: second owner tag aligned with m_data, then per-requester delivery
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag2_vld <= 1'b0;
      r_tag2_own <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_tag2_vld <= r_tag1_vld;
      r_tag2_own <= r_tag1_own;
      r_rvalid0  <= r_tag2_vld && !r_tag2_own;
      r_rvalid1  <= r_tag2_vld && r_tag2_own;
      if (r_tag2_vld && !r_tag2_own) begin
        r_rdata0 <= i_m_data;
      end
      if (r_tag2_vld && r_tag2_own) begin
        r_rdata1 <= i_m_data;
      end
    end
  end

  assign o_m_req     = r_m_req;
  assign o_m_addr    = r_m_addr;
  assign o_r0_gnt    = r_gnt0;
  assign o_r1_gnt    = r_gnt1;
  assign o_r0_rvalid = r_rvalid0;
  assign o_r1_rvalid = r_rvalid1;
  assign o_r0_rdata  = r_rdata0;
  assign o_r1_rdata  = r_rdata1;
  assign o_busy      = r_tag1_vld || r_tag2_vld || (r_state == StLocked);

endmodule

// File: tb/tb_gray_port_arbiter.sv
// Self-checking bench for gray_port_arbiter: per-scenario tasks check grants
// inline, while a scoreboard of expected read returns is drained by a monitor.

module tb_gray_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gray_ready = 1'b0;
  logic        m_req;
  logic [13:0] m_addr;
  logic [7:0]  m_data = 8'h00;
  logic        r0_req = 1'b0;
  logic [13:0] r0_addr = '0;
  logic        r0_lock = 1'b0;
  logic        r0_gnt;
  logic        r0_rvalid;
  logic [7:0]  r0_rdata;
  logic        r1_req = 1'b0;
  logic [13:0] r1_addr = '0;
  logic        r1_lock = 1'b0;
  logic        r1_gnt;
  logic        r1_rvalid;
  logic [7:0]  r1_rdata;
  logic        busy;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [13:0] last_addr = '0;
  exp_t        mon_e;
  logic [7:0]  mon_d;
  logic [7:0]  hold0 = '0;
  logic [7:0]  hold1 = '0;

  gray_port_arbiter #(
    .AW(14),
    .DW(8),
    .LOCK_MAX(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_gray_ready(gray_ready),
    .o_m_req    (m_req),
    .o_m_addr   (m_addr),
    .i_m_data   (m_data),
    .i_r0_req   (r0_req),
    .i_r0_addr  (r0_addr),
    .i_r0_lock  (r0_lock),
    .o_r0_gnt   (r0_gnt),
    .o_r0_rvalid(r0_rvalid),
    .o_r0_rdata (r0_rdata),
    .i_r1_req   (r1_req),
    .i_r1_addr  (r1_addr),
    .i_r1_lock  (r1_lock),
    .o_r1_gnt   (r1_gnt),
    .o_r1_rvalid(r1_rvalid),
    .o_r1_rdata (r1_rdata),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_f(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hA5;
  endfunction

  // Memory model: data valid the cycle after m_req, garbage otherwise
  always @(posedge clk) m_data <= m_req ? mem_f(m_addr) : 8'hEE;

  // Return monitor: pops the scoreboard on every rvalid, flags overdue entries
  always @(negedge clk) begin
    if (reset) begin
      hold0 = '0;
      hold1 = '0;
    end else begin
      if (r0_rvalid || r1_rvalid) begin
        n_total++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL rvalid_spurious cyc=%0d: rv0=%b rv1=%b, required no rvalid",
                   cyc, r0_rvalid, r1_rvalid);
        end else begin
          mon_e = sb.pop_front();
          mon_d = r1_rvalid ? r1_rdata : r0_rdata;
          if ((r0_rvalid && r1_rvalid) || r1_rvalid !== mon_e.id || mon_d !== mon_e.data ||
              cyc != mon_e.due) begin
            n_bad++;
            $display("FAIL rvalid_return cyc=%0d: rv0=%b rv1=%b data=%h, required id=%0d data=%h at cyc=%0d",
                     cyc, r0_rvalid, r1_rvalid, mon_d, mon_e.id, mon_e.data, mon_e.due);
          end
        end
        if (r0_rvalid) hold0 = r0_rdata;
        if (r1_rvalid) hold1 = r1_rdata;
      end
      if (!r0_rvalid && !r1_rvalid) begin
        n_total++;
        if (r0_rdata !== hold0 || r1_rdata !== hold1) begin
          n_bad++;
          $display("FAIL rdata_hold cyc=%0d: rdata0=%h rdata1=%h, required %h %h",
                   cyc, r0_rdata, r1_rdata, hold0, hold1);
        end
      end
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_total++;
        n_bad++;
        $display("FAIL rvalid_missing cyc=%0d: no rvalid, required id=%0d data=%h at cyc=%0d",
                 cyc, sb[0].id, sb[0].data, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    gray_ready = 1'b0;
    r0_req = 1'b0; r0_lock = 1'b0; r0_addr = '0;
    r1_req = 1'b0; r1_lock = 1'b0; r1_addr = '0;
    repeat (2) @(negedge clk);
    sb.delete();
    last_addr = '0;
    reset = 1'b0;
  endtask

  task automatic go_ready();
    gray_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if ({m_req, m_addr, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, busy} !== 36'd0)
    begin
      n_bad++;
      $display("FAIL reset_state: outputs=%h, required 0",
               {m_req, m_addr, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, busy});
    end
  endtask

  task automatic test_wait_ready();
    do_reset();
    r0_req = 1'b1;
    r0_addr = 14'h0123;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_total++;
      if (m_req !== 1'b0 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin
        n_bad++;
        $display("FAIL wait_rdy_nogrant k=%0d: m_req=%b g0=%b g1=%b, required 0 0 0",
                 k, m_req, r0_gnt, r1_gnt);
      end
    end
    gray_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (m_req !== 1'b0 || r0_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_rdy_early: m_req=%b g0=%b, required 0 0", m_req, r0_gnt);
    end
    last_addr = r0_addr;
    sb.push_back('{1'b0, mem_f(r0_addr), cyc + 3});
    @(negedge clk);
    n_total++;
    if (m_req !== 1'b1 || r0_gnt !== 1'b1 || r1_gnt !== 1'b0 || m_addr !== 14'h0123) begin
      n_bad++;
      $display("FAIL wait_rdy_first: m_req=%b g0=%b g1=%b addr=%h, required 1 1 0 0123",
               m_req, r0_gnt, r1_gnt, m_addr);
    end
    r0_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (m_req !== 1'b0 || r0_gnt !== 1'b0 || m_addr !== 14'h0123) begin
      n_bad++;
      $display("FAIL wait_rdy_hold: m_req=%b g0=%b addr=%h, required 0 0 0123",
               m_req, r0_gnt, m_addr);
    end
    drain();
    n_total++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_rdy_drain: pending=%0d busy=%b, required 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_alternate();
    int prev;
    do_reset();
    go_ready();
    prev = -1;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_total++;
        if (prev < 0) begin
          if (m_req !== 1'b0 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || m_addr !== last_addr) begin
            n_bad++;
            $display("FAIL alt_idle k=%0d: req=%b g0=%b g1=%b addr=%h, required 0 0 0 %h",
                     k, m_req, r0_gnt, r1_gnt, m_addr, last_addr);
          end
        end else if (m_req !== 1'b1 || r0_gnt !== (prev == 0) || r1_gnt !== (prev == 1) ||
                     m_addr !== last_addr) begin
          n_bad++;
          $display("FAIL alt_grant k=%0d: req=%b g0=%b g1=%b addr=%h, required grant r%0d addr=%h",
                   k, m_req, r0_gnt, r1_gnt, m_addr, prev, last_addr);
        end
      end
      if (k < 8) begin
        r0_req = 1'b1; r0_addr = 14'h0081;
        r1_req = 1'b1; r1_addr = 14'h0102;
        prev = k % 2;
        last_addr = (prev == 1) ? r1_addr : r0_addr;
        sb.push_back('{prev[0], mem_f(last_addr), cyc + 3});
      end else begin
        r0_req = 1'b0; r1_req = 1'b0;
        prev = -1;
      end
    end
    drain();
    n_total++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL alt_drain: pending=%0d busy=%b, required 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_lock_release();
    int prev;
    do_reset();
    go_ready();
    prev = -1;
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_total++;
        if (prev < 0) begin
          if (m_req !== 1'b0 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || m_addr !== last_addr) begin
            n_bad++;
            $display("FAIL lock_idle k=%0d: req=%b g0=%b g1=%b addr=%h, required 0 0 0 %h",
                     k, m_req, r0_gnt, r1_gnt, m_addr, last_addr);
          end
        end else if (m_req !== 1'b1 || r0_gnt !== (prev == 0) || r1_gnt !== (prev == 1) ||
                     m_addr !== last_addr) begin
          n_bad++;
          $display("FAIL lock_grant k=%0d: req=%b g0=%b g1=%b addr=%h, required grant r%0d addr=%h",
                   k, m_req, r0_gnt, r1_gnt, m_addr, prev, last_addr);
        end
      end
      if (k == 0) begin
        // one r0-only grant moves priority to r1 so r1 can open its window
        r0_req = 1'b1; r0_addr = 14'h0200; r1_req = 1'b0; r1_lock = 1'b0;
        prev = 0;
      end else if (k <= 9) begin
        r1_req = 1'b1; r1_lock = 1'b1;
        r1_addr = 14'(32'h81 + ((k - 1) / 3) * 128 + (k - 1) % 3);
        prev = 1;
      end else if (k == 10) begin
        r1_req = 1'b0; r1_lock = 1'b0;
        prev = -1;
      end else if (k == 11) begin
        prev = 0;
      end else begin
        r0_req = 1'b0;
        prev = -1;
      end
      if (prev >= 0) begin
        last_addr = (prev == 1) ? r1_addr : r0_addr;
        sb.push_back('{prev[0], mem_f(last_addr), cyc + 3});
      end
    end
    drain();
    n_total++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_drain: pending=%0d busy=%b, required 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_lock_max();
    int prev;
    do_reset();
    go_ready();
    prev = -1;
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_total++;
        if (prev < 0) begin
          if (m_req !== 1'b0 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || m_addr !== last_addr) begin
            n_bad++;
            $display("FAIL lockmax_idle k=%0d: req=%b g0=%b g1=%b addr=%h, required 0 0 0 %h",
                     k, m_req, r0_gnt, r1_gnt, m_addr, last_addr);
          end
        end else if (m_req !== 1'b1 || r0_gnt !== (prev == 0) || r1_gnt !== (prev == 1) ||
                     m_addr !== last_addr) begin
          n_bad++;
          $display("FAIL lockmax_grant k=%0d: req=%b g0=%b g1=%b addr=%h, required grant r%0d addr=%h",
                   k, m_req, r0_gnt, r1_gnt, m_addr, prev, last_addr);
        end
      end
      if (k <= 16) begin
        r0_req = 1'b1; r0_lock = 1'b1; r0_addr = 14'h0300 + 14'(k);
        r1_req = 1'b1; r1_lock = 1'b0; r1_addr = 14'h0055;
        prev = (k < 16) ? 0 : 1;
        last_addr = (prev == 1) ? r1_addr : r0_addr;
        sb.push_back('{prev[0], mem_f(last_addr), cyc + 3});
      end else begin
        r0_req = 1'b0; r0_lock = 1'b0; r1_req = 1'b0;
        prev = -1;
      end
    end
    drain();
    n_total++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL lockmax_drain: pending=%0d busy=%b, required 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_ready_drop();
    int prev;
    do_reset();
    go_ready();
    prev = -1;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_total++;
        if (prev < 0) begin
          if (m_req !== 1'b0 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || m_addr !== last_addr) begin
            n_bad++;
            $display("FAIL drop_idle k=%0d: req=%b g0=%b g1=%b addr=%h, required 0 0 0 %h",
                     k, m_req, r0_gnt, r1_gnt, m_addr, last_addr);
          end
        end else if (m_req !== 1'b1 || r0_gnt !== (prev == 0) || r1_gnt !== (prev == 1) ||
                     m_addr !== last_addr) begin
          n_bad++;
          $display("FAIL drop_grant k=%0d: req=%b g0=%b g1=%b addr=%h, required grant r%0d addr=%h",
                   k, m_req, r0_gnt, r1_gnt, m_addr, prev, last_addr);
        end
      end
      if (k == 4) begin
        n_total++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL drop_busy_inflight: busy=%b, required 1", busy);
        end
      end
      if (k == 5) begin
        n_total++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL drop_busy_after: busy=%b, required 0", busy);
        end
      end
      if (k < 3) begin
        gray_ready = 1'b1; r0_req = 1'b1; r0_addr = 14'h0400 + 14'(k);
        prev = 0;
        last_addr = r0_addr;
        sb.push_back('{1'b0, mem_f(last_addr), cyc + 3});
      end else if (k < 6) begin
        gray_ready = 1'b0; r0_req = 1'b1;
        prev = -1;
      end else begin
        r0_req = 1'b0;
        prev = -1;
      end
    end
    drain();
    n_total++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_drain: pending=%0d busy=%b, required 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_reset_midflight();
    bit saw_rv;
    do_reset();
    go_ready();
    r0_req = 1'b1; r0_addr = 14'h0155;
    last_addr = r0_addr;
    sb.push_back('{1'b0, mem_f(r0_addr), cyc + 3});
    @(negedge clk);
    n_total++;
    if (r0_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_first_gnt: g0=%b, required 1", r0_gnt);
    end
    r0_req = 1'b0;
    repeat (3) @(negedge clk);
    r1_req = 1'b1; r1_addr = 14'h0266;
    @(negedge clk);
    n_total++;
    if (r1_gnt !== 1'b1 || m_addr !== 14'h0266) begin
      n_bad++;
      $display("FAIL midrst_gnt: g1=%b addr=%h, required 1 0266", r1_gnt, m_addr);
    end
    reset = 1'b1;
    r1_req = 1'b0;
    sb.delete();
    #1;
    n_total++;
    if ({m_req, m_addr, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, busy} !== 36'd0)
    begin
      n_bad++;
      $display("FAIL midrst_outputs: outputs=%h, required 0",
               {m_req, m_addr, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, busy});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    saw_rv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (r0_rvalid || r1_rvalid) saw_rv = 1'b1;
    end
    n_total++;
    if (saw_rv || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_no_rvalid: saw_rvalid=%b busy=%b, required 0 0", saw_rv, busy);
    end
  endtask

  initial begin
    test_reset();
    test_wait_ready();
    test_alternate();
    test_lock_release();
    test_lock_max();
    test_ready_drop();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
